mem_bus_fabric: RTL
===================

Name: mem_bus_fabric

Overview:
Parametrised single-master memory bus fabric between the core's data port and NUM_SLAVES memory-mapped targets: RAM controller, ROM controller, VGA controller, UART and later peripherals.
- Replaces fixed point-to-point CPU-to-controller wiring in the top level.
- Decodes address top bits to a slave and runs a req/ack handshake with that slave.
- Bounds every access with a timeout and returns an error response on unmapped or hung accesses.

Parameters:
NUM_SLAVES, 4, number of slave channels (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_W, 4, address MSBs used as slave index (m_addr[ADDR_W-1 -: SEL_W])
TIMEOUT, 255, max cycles in ACCESS before error (1..65535)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m_req  in  1  master request, held until m_ack
m_we  in  1  1 = write, 0 = read
m_addr  in  ADDR_W  master address
m_wdata  in  DATA_W  master write data
m_rdata  out  DATA_W  read data, valid while m_ack=1
m_ack  out  1  one-cycle completion pulse
m_err  out  1  error flag, valid while m_ack=1
s_req  out  NUM_SLAVES  one-hot slave request
s_we  out  1  latched write enable, broadcast
s_addr  out  ADDR_W  latched full address, broadcast
s_wdata  out  DATA_W  latched write data, broadcast
s_rdata  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
s_ack  in  NUM_SLAVES  slave completion, per slave
stat_err_count  out  16  error response counter (see Optional Feature)

Behaviour:
- Reset (async on rst_n low):
  - State: IDLE.
  - Outputs: s_req=0, m_ack=0, m_err=0, m_rdata=0, s_we=0, s_addr=0, s_wdata=0, stat_err_count=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On an edge sampling m_req=1: latch m_we, m_addr and m_wdata into the s_* registers.
  - Decode idx = m_addr[ADDR_W-1 -: SEL_W].
  - If idx < NUM_SLAVES: set s_req[idx]=1, clear the timeout counter, go to ACCESS.
  - Otherwise (unmapped): set m_err=1 and m_rdata=0, go to RESP.
  - No slave is touched on an unmapped access.
- ACCESS:
  - s_req[idx] is held high and all s_* outputs are stable.
  - The counter increments each cycle.
  - Edge sampling s_ack[idx]=1:
    - capture s_rdata slice idx into m_rdata (writes also capture it; the master ignores it);
    - m_err=0, s_req=0;
    - go to RESP.
  - Otherwise, on the edge where the counter reaches TIMEOUT:
    - s_req=0, m_err=1, m_rdata=0;
    - go to RESP.
  - If s_ack and the timeout occur on the same edge, the ack wins.
  - s_ack from non-selected slaves is ignored in every state.
- RESP:
  - m_ack=1 for exactly one cycle, with m_err and m_rdata valid; then go to IDLE.
  - m_req is not sampled in RESP.
  - The master must drop m_req in the cycle after m_ack, otherwise IDLE accepts it as a new request.
- Latency:
  - Slave acking in its first ACCESS cycle: m_ack is high in cycle 2, counting the request-sampling edge as edge 0.
  - Unmapped access: m_ack is high in cycle 1.
  - Minimum initiation interval is 3 cycles (IDLE, ACCESS, RESP).
- Reset mid-access: s_req drops immediately (asynchronously) and no m_ack is produced. The slave must tolerate an abandoned request.
- Counter width is clog2(TIMEOUT+1) and it never wraps.

Optional Feature:
Macro MEM_BUS_FABRIC_STATS_EN.
- Defined: stat_err_count increments by 1 on every RESP cycle with m_err=1 and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: stat_err_count is tied to 0 and no counter flops exist.
- The port is present in both builds.

Decomposition:
- Package bus_pkg holds:
  - fabric state enum (IDLE/ACCESS/RESP);
  - default SEL_W and TIMEOUT constants;
  - a function computing the counter width.
- One combinational sub-module, bus_addr_decode:
  - inputs: m_addr;
  - outputs: idx[SEL_W-1:0] and mapped (idx < NUM_SLAVES);
  - reused later by DMA and debug masters.

Test Plan:
- Write to slave 1: m_addr=0x1000_0040, m_wdata=0xDEADBEEF, m_we=1; slave 1 acks after 3 cycles.
  Required: s_req=4'b0010, s_addr/s_wdata match; one m_ack pulse with m_err=0; stat_err_count stays 0.
- Read from slave 2: m_addr=0x2000_0000; slave 2 returns 0x12345678 with immediate ack.
  Required: m_ack in cycle 2, m_rdata=0x12345678, m_err=0.
- Unmapped access, NUM_SLAVES=4: m_addr=0x5000_0000.
  Required: s_req stays 0; m_ack and m_err high in cycle 1, m_rdata=0; stat_err_count=1 when STATS_EN is defined.
- Timeout, TIMEOUT=8: slave 3 never acks.
  Required: s_req[3] high for 8 cycles, then drops; next cycle m_ack=1, m_err=1.
  Also: s_ack[3] on the final counting edge gives m_err=0.
- Reset mid-access: rst_n low during ACCESS.
  Required: s_req=0 immediately, no m_ack, FSM in IDLE after release.
- Back-to-back: m_req held continuously across two accesses.
  Required: the second access starts at the IDLE edge after RESP; s_req never high during RESP.

Source files
------------

// File: rtl/mem_bus_fabric_pkg.sv
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared constants, FSM encoding and helpers for the memory bus fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  localparam int unsigned SEL_W_DEFAULT   = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Fabric FSM encoding
  typedef logic [1:0] fabric_state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Width needed to hold every value 0..timeout without wrapping.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_fabric_addr_decode.sv
// ============================================================================
// Module   : bus_addr_decode
// Brief    : Maps the top address bits to a slave index and flags unmapped ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_addr_decode #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned NUM_SLAVES = 4
) (
  input  logic [ADDR_W-1:0] m_addr,
  output logic [SEL_W-1:0]  idx,
  output logic              mapped
);

  assign idx    = m_addr[ADDR_W-1 -: SEL_W];
  assign mapped = (32'(idx) < NUM_SLAVES);

endmodule

`default_nettype wire

// File: rtl/mem_bus_fabric.sv
// ============================================================================
// Module   : mem_bus_fabric
// Brief    : Single-master req/ack bus fabric with address decode and timeout.
//            Optional error statistics counter: MEM_BUS_FABRIC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_fabric
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_W      = SEL_W_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  output logic [15:0]                  stat_err_count
);

  localparam int unsigned         CNT_W       = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_TIMEOUT = CNT_W'(TIMEOUT);

  fabric_state_t           state_q,   state_d;
  logic [NUM_SLAVES-1:0]   s_req_q,   s_req_d;
  logic                    s_we_q,    s_we_d;
  logic [ADDR_W-1:0]       s_addr_q,  s_addr_d;
  logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
  logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
  logic                    m_ack_q,   m_ack_d;
  logic                    m_err_q,   m_err_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;

  logic [SEL_W-1:0]        dec_idx;
  logic                    dec_mapped;
  logic                    sel_ack;
  logic [DATA_W-1:0]       sel_rdata;

  bus_addr_decode #(
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_addr_decode (
    .m_addr (m_addr),
    .idx    (dec_idx),
    .mapped (dec_mapped)
  );

  // s_req_q is one-hot, so it doubles as the ack/rdata select and masks
  // acks from every other slave.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (s_req_q[i]) begin
        sel_ack   = sel_ack | s_ack[i];
        sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_err_d   = m_err_q;
    m_ack_d   = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          s_we_d    = m_we;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          if (dec_mapped) begin
            for (int i = 0; i < int'(NUM_SLAVES); i++) begin
              s_req_d[i] = (dec_idx == SEL_W'(i));
            end
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end else begin
            m_err_d   = 1'b1;
            m_rdata_d = '0;
            m_ack_d   = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // An ack on the final counting edge takes priority over the timeout.
        if (sel_ack) begin
          m_rdata_d = sel_rdata;
          m_err_d   = 1'b0;
          s_req_d   = '0;
          m_ack_d   = 1'b1;
          state_d   = ST_RESP;
        end else if (cnt_d == CNT_TIMEOUT) begin
          m_rdata_d = '0;
          m_err_d   = 1'b1;
          s_req_d   = '0;
          m_ack_d   = 1'b1;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        s_req_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_req_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign m_rdata = m_rdata_q;
  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;

`ifdef MEM_BUS_FABRIC_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == ST_RESP) && m_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_err_count = err_cnt_q;
`else
  assign stat_err_count = 16'd0;
`endif

endmodule

`default_nettype wire
